// File: rtl/muldiv_seq_ctrl.sv
// Multi-cycle sequencer for M-extension mul/div: step counter, divider strobes, completion and stall request.
// Optional MULDIV_DIV0_BYPASS_EN: divide-by-zero completes in the start cycle without entering DIV.
module muldiv_seq_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 17,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic             is_m_i,
  input  logic             is_d_i,
  input  logic             rs2_zero_i,
  input  logic             ex_ready_i,
  output logic [CNT_W-1:0] step_o,
  output logic             d_init_o,
  output logic             d_advance_o,
  output logic             d_last_o,
  output logic             fin_o,
  output logic             div0_o,
  output logic             busy_o,
  output logic             stall_req_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_m, start_d;

`ifndef MULDIV_DIV0_BYPASS_EN
  logic unused_rs2_zero;
  assign unused_rs2_zero = rs2_zero_i;
`endif

  // Starts are gated by resetn so every output stays low while reset is held.
  assign start_m = resetn & (state_q == S_IDLE) & valid_i & is_m_i & ~flush_i;
  assign start_d = resetn & (state_q == S_IDLE) & valid_i & is_d_i & ~is_m_i & ~flush_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_o      = '0;
    d_init_o    = 1'b0;
    d_advance_o = 1'b0;
    d_last_o    = 1'b0;
    fin_o       = 1'b0;
    div0_o      = 1'b0;
    busy_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_m) begin
          busy_o = 1'b1;
          if (MUL_CYCLES == 1) begin
            fin_o = 1'b1;
          end else if (ex_ready_i) begin
            cnt_d   = CNT_ONE;
            state_d = S_MUL;
          end
        end else if (start_d) begin
          busy_o   = 1'b1;
          d_init_o = 1'b1;
`ifdef MULDIV_DIV0_BYPASS_EN
          if (rs2_zero_i) begin
            fin_o  = 1'b1;
            div0_o = 1'b1;
          end else if (ex_ready_i) begin
            cnt_d   = CNT_ONE;
            state_d = S_DIV;
          end
`else
          if (ex_ready_i) begin
            cnt_d   = CNT_ONE;
            state_d = S_DIV;
          end
`endif
        end
      end

      S_MUL: begin
        step_o = cnt_q;
        busy_o = 1'b1;
        // Terminal compare precedes the increment, so cnt never wraps.
        if (cnt_q == MUL_LAST) begin
          fin_o = 1'b1;
          if (ex_ready_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else if (ex_ready_i) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DIV: begin
        step_o      = cnt_q;
        busy_o      = 1'b1;
        d_advance_o = 1'b1;
        if (cnt_q == DIV_LAST) begin
          d_last_o = 1'b1;
          fin_o    = 1'b1;
          if (ex_ready_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else if (ex_ready_i) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Flush overrides both start and completion in the same cycle.
    if (flush_i) begin
      step_o      = '0;
      d_init_o    = 1'b0;
      d_advance_o = 1'b0;
      d_last_o    = 1'b0;
      fin_o       = 1'b0;
      div0_o      = 1'b0;
      busy_o      = 1'b0;
      state_d     = S_IDLE;
      cnt_d       = '0;
    end
  end

  assign stall_req_o = busy_o & ~fin_o;

endmodule
